// File: rtl/rps_referee.sv
// rps_referee: rock-paper-scissors round controller between player input and the move predictor.
// Optional RPS_REFEREE_HISTORY_EN keeps a 32-bit shift record of the last 8 {user, cpu} pairs.
module rps_referee #(
    parameter int ROUNDS  = 60,
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 200,
    parameter int SCORE_W = 7
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               move_valid,
    input  logic [1:0]         move,
    output logic               move_ready,
    output logic               bad_move,
    output logic [1:0]         pred_user,
    input  logic [1:0]         pred_choice,
    input  logic               pred_ready,
    output logic               start,
    output logic               result_valid,
    output logic [1:0]         result,
    output logic [1:0]         cpu_move,
    output logic               timeout,
    output logic [SCORE_W-1:0] user_score,
    output logic [SCORE_W-1:0] cpu_score,
    output logic [SCORE_W-1:0] tie_count,
    output logic [5:0]         round,
    output logic               game_over,
    output logic [31:0]        history,
    output logic [2:0]         dbg_state
);
    // Handshake: a move transfers on any rising edge where move_valid && move_ready; move_ready is
    // high only in IDLE, and move_valid in every other state is ignored (nothing is buffered).
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRESENT   = 3'd1,
        ST_WAIT_PRED = 3'd2,
        ST_JUDGE     = 3'd3,
        ST_COMMIT    = 3'd4,
        ST_OVER      = 3'd5
    } state_t;

    localparam int CNT_MAX = (SETTLE > TIMEOUT) ? SETTLE : TIMEOUT;
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0]   SETTLE_LAST  = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [5:0]         ROUNDS_L     = 6'(ROUNDS);
    localparam logic [SCORE_W-1:0] SCORE_MAX    = '1;

    localparam logic [1:0] MV_ROCK    = 2'b00;
    localparam logic [1:0] MV_SCIS    = 2'b01;
    localparam logic [1:0] MV_PAPER   = 2'b10;
    localparam logic [1:0] MV_ILLEGAL = 2'b11;
    localparam logic [1:0] RES_TIE    = 2'b00;
    localparam logic [1:0] RES_CPU    = 2'b01;
    localparam logic [1:0] RES_USER   = 2'b10;

    state_t             r_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [1:0]         r_fb;
    logic               r_to_flag;
    logic [1:0]         r_pred_user;
    logic [1:0]         r_cpu_move;
    logic [1:0]         r_result;
    logic [SCORE_W-1:0] r_user;
    logic [SCORE_W-1:0] r_cpu;
    logic [SCORE_W-1:0] r_tie;
    logic [5:0]         r_round;
    logic               r_bad_move;

    logic       w_accept;
    logic       w_legal;
    logic       w_settle_done;
    logic       w_wait_done;
    logic       w_tie;
    logic       w_cpu_wins;
    logic [1:0] w_result;
    logic [1:0] w_pred_move;

    assign w_accept      = (r_state == ST_IDLE) && move_valid;
    assign w_legal       = (move != MV_ILLEGAL);
    assign w_settle_done = (r_cnt == SETTLE_LAST);
    assign w_wait_done   = (r_cnt == TIMEOUT_LAST);
    assign w_pred_move   = (pred_choice == MV_ILLEGAL) ? r_fb : pred_choice;

    // Each move beats the one encoded directly after it: rock>scissors>paper>rock.
    always_comb begin
        w_tie      = (r_pred_user == r_cpu_move);
        w_cpu_wins = ((r_cpu_move == MV_ROCK)  && (r_pred_user == MV_SCIS))  ||
                     ((r_cpu_move == MV_SCIS)  && (r_pred_user == MV_PAPER)) ||
                     ((r_cpu_move == MV_PAPER) && (r_pred_user == MV_ROCK));
        w_result   = w_tie ? RES_TIE : (w_cpu_wins ? RES_CPU : RES_USER);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:      if (w_accept && w_legal) w_next_state = ST_PRESENT;
            ST_PRESENT:   if (w_settle_done) w_next_state = ST_WAIT_PRED;
            ST_WAIT_PRED: if (pred_ready || w_wait_done) w_next_state = ST_JUDGE;
            ST_JUDGE:     w_next_state = ST_COMMIT;
            ST_COMMIT:    w_next_state = (r_round == ROUNDS_L) ? ST_OVER : ST_IDLE;
            ST_OVER:      w_next_state = ST_OVER;
            default:      w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt       <= '0;
            r_fb        <= 2'd0;
            r_to_flag   <= 1'b0;
            r_pred_user <= 2'b00;
            r_cpu_move  <= 2'b00;
            r_result    <= RES_TIE;
            r_user      <= '0;
            r_cpu       <= '0;
            r_tie       <= '0;
            r_round     <= 6'd0;
            r_bad_move  <= 1'b0;
        end else begin
            r_fb       <= (r_fb == 2'd2) ? 2'd0 : r_fb + 2'd1;
            r_bad_move <= w_accept && !w_legal;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && w_legal) begin
                        r_pred_user <= move;
                        r_cnt       <= '0;
                        r_to_flag   <= 1'b0;
                    end
                end
                ST_PRESENT: begin
                    r_cnt <= w_settle_done ? '0 : r_cnt + CNT_W'(1);
                end
                ST_WAIT_PRED: begin
                    if (pred_ready) begin
                        r_cpu_move <= w_pred_move;
                    end else if (w_wait_done) begin
                        r_cpu_move <= r_fb;
                        r_to_flag  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_JUDGE: begin
                    r_result <= w_result;
                    r_round  <= r_round + 6'd1;
                    if (w_tie) begin
                        if (r_tie != SCORE_MAX) r_tie <= r_tie + SCORE_W'(1);
                    end else if (w_cpu_wins) begin
                        if (r_cpu != SCORE_MAX) r_cpu <= r_cpu + SCORE_W'(1);
                    end else begin
                        if (r_user != SCORE_MAX) r_user <= r_user + SCORE_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef RPS_REFEREE_HISTORY_EN
    logic [31:0] r_history;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_history <= 32'd0;
        end else if (r_state == ST_JUDGE) begin
            r_history <= {r_history[27:0], r_pred_user, r_cpu_move};
        end
    end

    assign history = r_history;
`else
    assign history = 32'd0;
`endif

    assign move_ready   = (r_state == ST_IDLE);
    assign bad_move     = r_bad_move;
    assign pred_user    = r_pred_user;
    assign start        = (r_state != ST_COMMIT);
    assign result_valid = (r_state == ST_COMMIT);
    assign result       = r_result;
    assign cpu_move     = r_cpu_move;
    assign timeout      = (r_state == ST_COMMIT) && r_to_flag;
    assign user_score   = r_user;
    assign cpu_score    = r_cpu;
    assign tie_count    = r_tie;
    assign round        = r_round;
    assign game_over    = (r_round == ROUNDS_L);
    assign dbg_state    = r_state;
endmodule

// File: tb/tb_rps_referee.sv
// Directed bench for rps_referee: cycle timing, all move pairs, illegal moves, timeout fallback,
// end of game and reset behaviour, with hand-computed expected results.
module tb_rps_referee;
    localparam int ROUNDS  = 12;
    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 10;
    localparam int SCORE_W = 7;

    logic               clock = 1'b0;
    logic               reset;
    logic               move_valid;
    logic [1:0]         move;
    logic               move_ready;
    logic               bad_move;
    logic [1:0]         pred_user;
    logic [1:0]         pred_choice;
    logic               pred_ready;
    logic               start;
    logic               result_valid;
    logic [1:0]         result;
    logic [1:0]         cpu_move;
    logic               timeout;
    logic [SCORE_W-1:0] user_score;
    logic [SCORE_W-1:0] cpu_score;
    logic [SCORE_W-1:0] tie_count;
    logic [5:0]         round;
    logic               game_over;
    logic [31:0]        history;
    logic [2:0]         dbg_state;

    always #5 clock = ~clock;

    rps_referee #(
        .ROUNDS(ROUNDS), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT), .SCORE_W(SCORE_W)
    ) dut (
        .clock(clock), .reset(reset), .move_valid(move_valid), .move(move),
        .move_ready(move_ready), .bad_move(bad_move), .pred_user(pred_user),
        .pred_choice(pred_choice), .pred_ready(pred_ready), .start(start),
        .result_valid(result_valid), .result(result), .cpu_move(cpu_move),
        .timeout(timeout), .user_score(user_score), .cpu_score(cpu_score),
        .tie_count(tie_count), .round(round), .game_over(game_over),
        .history(history), .dbg_state(dbg_state)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [1:0]  exp_res_tbl [9];
    int          exp_user, exp_cpu, exp_tie, exp_round;
    logic [31:0] exp_hist;
    logic [1:0]  exp_pred_user;
    logic [1:0]  m_fb;

    // Reference for the free-running fallback counter (0,1,2,0,... from reset).
    always @(posedge clock) begin
        if (reset) m_fb <= 2'd0;
        else       m_fb <= (m_fb == 2'd2) ? 2'd0 : m_fb + 2'd1;
    end

    function automatic logic [31:0] exp_history();
`ifdef RPS_REFEREE_HISTORY_EN
        return exp_hist;
`else
        return 32'd0;
`endif
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic reset_dut();
        reset = 1'b1; move_valid = 1'b0; move = 2'b00; pred_ready = 1'b0; pred_choice = 2'b00;
        tick();
        tick();
        reset = 1'b0;
        exp_user = 0; exp_cpu = 0; exp_tie = 0; exp_round = 0; exp_hist = 32'd0; exp_pred_user = 2'b00;
    endtask

    task automatic record_round(input logic [1:0] u, input logic [1:0] cm, input logic [1:0] r);
        case (r)
            2'b00:   exp_tie++;
            2'b01:   exp_cpu++;
            default: exp_user++;
        endcase
        exp_round++;
        exp_hist      = {exp_hist[27:0], u, cm};
        exp_pred_user = u;
    endtask

    // Offers one move at the current cycle (cycle 0) and runs until the cycle after result_valid.
    task automatic play_round(input logic [1:0] u, input logic [1:0] c, input logic rdy,
                              output int rv_cyc, output logic [1:0] res, output logic [1:0] cm,
                              output logic to, output int n_start, output logic [1:0] fbv);
        rv_cyc = -1; res = 2'b00; cm = 2'b00; to = 1'b0; n_start = 0; fbv = 2'b00;
        move = u; pred_choice = c; pred_ready = rdy; move_valid = 1'b1;
        tick();
        move_valid = 1'b0;
        for (int k = 1; k <= 300; k++) begin
            if (start === 1'b0) n_start++;
            if (result_valid === 1'b1) begin
                rv_cyc = k; res = result; cm = cpu_move; to = timeout; fbv = m_fb;
                break;
            end
            tick();
        end
        tick();
    endtask

    task automatic test_reset();
        reset_dut();
        n_checks++; if (move_ready !== 1'b1) $display("FAIL reset_move_ready: got %b want 1", move_ready); else n_pass++;
        n_checks++; if (start !== 1'b1) $display("FAIL reset_start: got %b want 1", start); else n_pass++;
        n_checks++; if ({result_valid, bad_move, timeout, game_over} !== 4'b0000) $display("FAIL reset_pulses: got %b want 0000", {result_valid, bad_move, timeout, game_over}); else n_pass++;
        n_checks++; if ({result, cpu_move, pred_user} !== 6'd0) $display("FAIL reset_moves: got %b want 000000", {result, cpu_move, pred_user}); else n_pass++;
        n_checks++; if ({user_score, cpu_score, tie_count} !== 21'd0) $display("FAIL reset_scores: got %0d/%0d/%0d want 0/0/0", user_score, cpu_score, tie_count); else n_pass++;
        n_checks++; if (round !== 6'd0) $display("FAIL reset_round: got %0d want 0", round); else n_pass++;
        n_checks++; if (history !== 32'd0) $display("FAIL reset_history: got %h want 0", history); else n_pass++;
        n_checks++; if (dbg_state !== 3'd0) $display("FAIL reset_state: got %0d want 0", dbg_state); else n_pass++;
    endtask

    task automatic test_basic();
        int rv_n;
        int st_n;
        rv_n = 0; st_n = 0;
        move = 2'b00; pred_choice = 2'b10; pred_ready = 1'b1; move_valid = 1'b1;
        n_checks++; if (move_ready !== 1'b1) $display("FAIL basic_ready_c0: got %b want 1", move_ready); else n_pass++;
        for (int k = 1; k <= 9; k++) begin
            tick();
            move_valid = 1'b0;
            if (result_valid === 1'b1) rv_n++;
            if (start === 1'b0) st_n++;
            if (k == 7) begin
                n_checks++; if (result_valid !== 1'b1) $display("FAIL basic_rv_c7: got %b want 1", result_valid); else n_pass++;
                n_checks++; if (start !== 1'b0) $display("FAIL basic_start_c7: got %b want 0", start); else n_pass++;
                n_checks++; if (result !== 2'b01) $display("FAIL basic_result: got %b want 01", result); else n_pass++;
                n_checks++; if (cpu_score !== 7'd1 || user_score !== 7'd0 || tie_count !== 7'd0) $display("FAIL basic_scores: got %0d/%0d/%0d want 0/1/0", user_score, cpu_score, tie_count); else n_pass++;
                n_checks++; if (round !== 6'd1) $display("FAIL basic_round: got %0d want 1", round); else n_pass++;
                n_checks++; if (move_ready !== 1'b0) $display("FAIL basic_ready_c7: got %b want 0", move_ready); else n_pass++;
                n_checks++; if (pred_user !== 2'b00) $display("FAIL basic_pred_user: got %b want 00", pred_user); else n_pass++;
            end
            if (k == 8) begin
                n_checks++; if (move_ready !== 1'b1) $display("FAIL basic_ready_c8: got %b want 1", move_ready); else n_pass++;
            end
        end
        n_checks++; if (rv_n !== 1) $display("FAIL basic_rv_count: got %0d want 1", rv_n); else n_pass++;
        n_checks++; if (st_n !== 1) $display("FAIL basic_start_count: got %0d want 1", st_n); else n_pass++;
    endtask

    task automatic test_all_combos();
        int rv; int ns; logic [1:0] res; logic [1:0] cm; logic to; logic [1:0] fbv;
        logic [1:0] u; logic [1:0] c;
        reset_dut();
        for (int i = 0; i < 9; i++) begin
            u = 2'(i / 3);
            c = 2'(i % 3);
            n_checks++; if (move_ready !== 1'b1) $display("FAIL combo%0d_ready: got %b want 1", i, move_ready); else n_pass++;
            play_round(u, c, 1'b1, rv, res, cm, to, ns, fbv);
            n_checks++; if (rv !== 7) $display("FAIL combo%0d_latency: got %0d want 7", i, rv); else n_pass++;
            n_checks++; if (res !== exp_res_tbl[i]) $display("FAIL combo%0d_result: got %b want %b", i, res, exp_res_tbl[i]); else n_pass++;
            n_checks++; if (cm !== c) $display("FAIL combo%0d_cpu_move: got %b want %b", i, cm, c); else n_pass++;
            n_checks++; if (ns !== 1 || to !== 1'b0) $display("FAIL combo%0d_start_timeout: got %0d,%b want 1,0", i, ns, to); else n_pass++;
            record_round(u, c, exp_res_tbl[i]);
        end
        n_checks++; if (cpu_score !== 7'd3 || user_score !== 7'd3 || tie_count !== 7'd3) $display("FAIL combo_final_scores: got %0d/%0d/%0d want 3/3/3", user_score, cpu_score, tie_count); else n_pass++;
        n_checks++; if (round !== 6'd9) $display("FAIL combo_final_round: got %0d want 9", round); else n_pass++;
        n_checks++; if (history !== exp_history()) $display("FAIL combo_history: got %h want %h", history, exp_history()); else n_pass++;
    endtask

    task automatic test_bad_move();
        int st_n;
        int rv_n;
        st_n = 0; rv_n = 0;
        move = 2'b11; move_valid = 1'b1;
        n_checks++; if (move_ready !== 1'b1) $display("FAIL bad_ready: got %b want 1", move_ready); else n_pass++;
        tick();
        move_valid = 1'b0;
        n_checks++; if (bad_move !== 1'b1) $display("FAIL bad_pulse: got %b want 1", bad_move); else n_pass++;
        n_checks++; if (dbg_state !== 3'd0) $display("FAIL bad_state: got %0d want 0", dbg_state); else n_pass++;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (start === 1'b0) st_n++;
            if (result_valid === 1'b1) rv_n++;
            if (k == 0) begin
                n_checks++; if (bad_move !== 1'b0) $display("FAIL bad_pulse_end: got %b want 0", bad_move); else n_pass++;
            end
        end
        n_checks++; if (st_n !== 0 || rv_n !== 0) $display("FAIL bad_no_commit: got start %0d rv %0d want 0 0", st_n, rv_n); else n_pass++;
        n_checks++; if (user_score !== 7'(exp_user) || cpu_score !== 7'(exp_cpu) || tie_count !== 7'(exp_tie) || round !== 6'(exp_round)) $display("FAIL bad_counters: got %0d/%0d/%0d r%0d want %0d/%0d/%0d r%0d", user_score, cpu_score, tie_count, round, exp_user, exp_cpu, exp_tie, exp_round); else n_pass++;
        n_checks++; if (pred_user !== exp_pred_user) $display("FAIL bad_pred_user: got %b want %b", pred_user, exp_pred_user); else n_pass++;
    endtask

    task automatic test_timeout();
        int rv; int ns; logic [1:0] res; logic [1:0] cm; logic to; logic [1:0] fbv; logic [1:0] exp_cm;
        play_round(2'b01, 2'b00, 1'b0, rv, res, cm, to, ns, fbv);
        // The fallback was sampled two cycles before result_valid.
        exp_cm = (fbv == 2'd2) ? 2'd0 : fbv + 2'd1;
        n_checks++; if (rv !== SETTLE + TIMEOUT + 2) $display("FAIL to_latency: got %0d want %0d", rv, SETTLE + TIMEOUT + 2); else n_pass++;
        n_checks++; if (to !== 1'b1) $display("FAIL to_flag: got %b want 1", to); else n_pass++;
        n_checks++; if (cm !== exp_cm) $display("FAIL to_cpu_move: got %b want %b", cm, exp_cm); else n_pass++;
        n_checks++; if (res !== exp_res_tbl[3 + int'(exp_cm)]) $display("FAIL to_result: got %b want %b", res, exp_res_tbl[3 + int'(exp_cm)]); else n_pass++;
        record_round(2'b01, exp_cm, exp_res_tbl[3 + int'(exp_cm)]);
        n_checks++; if (timeout !== 1'b0) $display("FAIL to_pulse_end: got %b want 0", timeout); else n_pass++;
        n_checks++; if (user_score !== 7'(exp_user) || cpu_score !== 7'(exp_cpu) || tie_count !== 7'(exp_tie) || round !== 6'd10) $display("FAIL to_counters: got %0d/%0d/%0d r%0d want %0d/%0d/%0d r10", user_score, cpu_score, tie_count, round, exp_user, exp_cpu, exp_tie); else n_pass++;
    endtask

    task automatic test_illegal_pred();
        int rv; int ns; logic [1:0] res; logic [1:0] cm; logic to; logic [1:0] fbv; logic [1:0] exp_cm;
        play_round(2'b00, 2'b11, 1'b1, rv, res, cm, to, ns, fbv);
        exp_cm = (fbv == 2'd2) ? 2'd0 : fbv + 2'd1;
        n_checks++; if (rv !== 7) $display("FAIL ip_latency: got %0d want 7", rv); else n_pass++;
        n_checks++; if (to !== 1'b0) $display("FAIL ip_flag: got %b want 0", to); else n_pass++;
        n_checks++; if (cm !== exp_cm) $display("FAIL ip_cpu_move: got %b want %b", cm, exp_cm); else n_pass++;
        n_checks++; if (res !== exp_res_tbl[int'(exp_cm)]) $display("FAIL ip_result: got %b want %b", res, exp_res_tbl[int'(exp_cm)]); else n_pass++;
        record_round(2'b00, exp_cm, exp_res_tbl[int'(exp_cm)]);
        n_checks++; if (game_over !== 1'b0 || round !== 6'd11) $display("FAIL ip_not_over: got go %b r%0d want 0 r11", game_over, round); else n_pass++;
        n_checks++; if (history !== exp_history()) $display("FAIL ip_history: got %h want %h", history, exp_history()); else n_pass++;
    endtask

    task automatic test_game_over();
        int rv; int ns; logic [1:0] res; logic [1:0] cm; logic to; logic [1:0] fbv;
        int ev_n;
        ev_n = 0;
        play_round(2'b10, 2'b01, 1'b1, rv, res, cm, to, ns, fbv);
        n_checks++; if (res !== 2'b01) $display("FAIL go_last_result: got %b want 01", res); else n_pass++;
        record_round(2'b10, 2'b01, 2'b01);
        n_checks++; if (game_over !== 1'b1 || round !== 6'd12) $display("FAIL go_flag: got go %b r%0d want 1 r12", game_over, round); else n_pass++;
        n_checks++; if (move_ready !== 1'b0) $display("FAIL go_ready: got %b want 0", move_ready); else n_pass++;
        n_checks++; if (dbg_state !== 3'd5) $display("FAIL go_state: got %0d want 5", dbg_state); else n_pass++;
        move_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            move = (k < 4) ? 2'b00 : 2'b11;
            tick();
            if (result_valid === 1'b1 || start === 1'b0 || bad_move === 1'b1 || dbg_state !== 3'd5) ev_n++;
        end
        move_valid = 1'b0;
        n_checks++; if (ev_n !== 0) $display("FAIL go_ignored: got %0d events want 0", ev_n); else n_pass++;
        n_checks++; if (round !== 6'd12 || pred_user !== 2'b10) $display("FAIL go_held: got r%0d pu %b want r12 pu 10", round, pred_user); else n_pass++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_user = 0; exp_cpu = 0; exp_tie = 0; exp_round = 0; exp_hist = 32'd0; exp_pred_user = 2'b00;
        n_checks++; if (move_ready !== 1'b1 || game_over !== 1'b0) $display("FAIL go_reset_ready: got ready %b go %b want 1 0", move_ready, game_over); else n_pass++;
        n_checks++; if ({user_score, cpu_score, tie_count} !== 21'd0 || round !== 6'd0) $display("FAIL go_reset_counters: got %0d/%0d/%0d r%0d want 0/0/0 r0", user_score, cpu_score, tie_count, round); else n_pass++;
        n_checks++; if ({result, cpu_move, pred_user} !== 6'd0 || history !== 32'd0) $display("FAIL go_reset_regs: got %b hist %h want 0", {result, cpu_move, pred_user}, history); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int ev_n;
        ev_n = 0;
        move = 2'b00; pred_ready = 1'b0; pred_choice = 2'b10; move_valid = 1'b1;
        tick();
        move_valid = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        n_checks++; if (dbg_state !== 3'd2) $display("FAIL mid_in_wait: got %0d want 2", dbg_state); else n_pass++;
        reset = 1'b1;
        pred_ready = 1'b1;
        tick();
        reset = 1'b0;
        pred_ready = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (result_valid === 1'b1 || start === 1'b0) ev_n++;
            tick();
        end
        n_checks++; if (ev_n !== 0) $display("FAIL mid_no_commit: got %0d events want 0", ev_n); else n_pass++;
        n_checks++; if ({user_score, cpu_score, tie_count} !== 21'd0 || round !== 6'd0) $display("FAIL mid_counters: got %0d/%0d/%0d r%0d want 0/0/0 r0", user_score, cpu_score, tie_count, round); else n_pass++;
        n_checks++; if (history !== 32'd0 || dbg_state !== 3'd0) $display("FAIL mid_history_state: got %h st%0d want 0 st0", history, dbg_state); else n_pass++;
    endtask

    initial begin
        exp_res_tbl[0] = 2'b00; exp_res_tbl[1] = 2'b10; exp_res_tbl[2] = 2'b01;
        exp_res_tbl[3] = 2'b01; exp_res_tbl[4] = 2'b00; exp_res_tbl[5] = 2'b10;
        exp_res_tbl[6] = 2'b10; exp_res_tbl[7] = 2'b01; exp_res_tbl[8] = 2'b00;
        test_reset();
        test_basic();
        test_all_combos();
        test_bad_move();
        test_timeout();
        test_illegal_pred();
        test_game_over();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/rps_referee.md
# rps_referee

Round controller sitting between the player input logic and the move predictor (`markov`/`reinforce`). It accepts one player move per round and presents it to the predictor. It then waits for the predictor's move, judges the round, keeps the score, and issues the active-low `start` commit strobe that makes the predictor learn from the round. After `ROUNDS` rounds it stops accepting moves until reset.

## Interface
Parameters:
- `ROUNDS`, 60: rounds per game (1..63).
- `SETTLE`, 4: cycles the user move is held on `pred_user` before `pred_ready` is sampled (≥1).
- `TIMEOUT`, 200: max cycles waiting for `pred_ready` before fallback (≥1).
- `SCORE_W`, 7: width of score counters.

Ports:
- `clock` in 1: single clock, all logic rising-edge.
- `reset` in 1: synchronous, active-high.
- `move_valid` in 1: player move offered.
- `move` in 2: 00 rock, 01 scissors, 10 paper, 11 illegal.
- `move_ready` out 1: high only in IDLE.
- `bad_move` out 1: one-cycle pulse when an illegal move is accepted and dropped.
- `pred_user` out 2: registered user move to predictor, held from accept through COMMIT.
- `pred_choice` in 2: predictor move, same encoding.
- `pred_ready` in 1: predictor move valid.
- `start` out 1: active-low commit strobe to predictor, low for exactly one cycle per round.
- `result_valid` out 1: one-cycle pulse per judged round.
- `result` out 2: 00 tie, 01 cpu wins, 10 user wins.
- `cpu_move` out 2: move actually used for judging.
- `timeout` out 1: one-cycle pulse, coincident with `result_valid`, when the fallback move was used.
- `user_score`, `cpu_score`, `tie_count` out SCORE_W: saturating counters.
- `round` out 6: completed rounds.
- `game_over` out 1: high once `round == ROUNDS`.
- `history` out 32: last 8 rounds (see Configuration).

## Operation
- States: IDLE, PRESENT, WAIT_PRED, JUDGE, COMMIT, OVER.
- IDLE: `move_ready`=1. On `move_valid`, the move is accepted.
  - Legal move: latch into `pred_user`, go to PRESENT.
  - `move==11`: pulse `bad_move`, stay in IDLE, no other state change.
- PRESENT: count `SETTLE` cycles, then go to WAIT_PRED.
- WAIT_PRED: a wait counter starts at 0.
  - If `pred_ready` is high (including the first cycle), latch `pred_choice` into `cpu_move` and go to JUDGE.
  - Otherwise, when the counter reaches `TIMEOUT`, latch the fallback value, set the timeout flag, and go to JUDGE.
  - A `pred_choice` of 11 is replaced by the fallback value (flag not set).
- Fallback: free-running mod-3 counter 0→1→2→0, advancing every cycle from reset.
- JUDGE: compute the outcome from `pred_user` and `cpu_move`.
  - cpu wins: rock beats scissors, scissors beats paper, paper beats rock.
  - Increment exactly one of `cpu_score`/`user_score`/`tie_count`, saturating at all-ones.
  - Register `result`. Go to COMMIT.
- COMMIT: `start`=0, `result_valid`=1, `timeout` = flag, `round`+1.
  - Go to OVER if the new `round == ROUNDS`, else IDLE.
- OVER: `game_over`=1, `move_ready`=0. `move_valid` is ignored; `bad_move` is never pulsed. Left only by reset.
- `move_valid` in any non-IDLE state is ignored.

## Timing
- Reset values: state IDLE, `move_ready`=1, `start`=1, `result_valid`=0, `bad_move`=0, `timeout`=0, `result`=00, `cpu_move`=00, `pred_user`=00, all scores 0, `round`=0, `game_over`=0, `history`=0, fallback counter 0.
- Round timeline, with accept at cycle 0:
  - PRESENT: cycles 1..SETTLE.
  - WAIT_PRED: first at cycle SETTLE+1.
  - JUDGE: SETTLE+2 (if ready immediately).
  - COMMIT: SETTLE+3. `start` low, `result_valid` high, and updated scores/`round` all visible this cycle.
  - IDLE with `move_ready`=1: SETTLE+4.
- Default case: 7-cycle latency to `result_valid`, 8-cycle round period.
- Timeout adds up to TIMEOUT cycles; `timeout` asserts in COMMIT.
- Reset in any state takes priority on that edge. A round in flight is discarded: no `start` pulse, no score change.

## Configuration
- `RPS_REFEREE_HISTORY_EN` defined: each COMMIT shifts `{pred_user, cpu_move}` into `history[3:0]`, older entries moving up 4 bits; the oldest is dropped.
- Undefined: `history` tied to 0; no history registers.

## Test plan
- SETTLE=4, `pred_ready` held 1, user rock, `pred_choice` paper:
  - `result_valid` at cycle 7 with `result`=01, `cpu_score`=1.
  - `start` low exactly at cycle 7; `move_ready` back at cycle 8.
- All 9 legal user×cpu combinations:
  - expected `result` each time.
  - final `cpu_score`=3, `user_score`=3, `tie_count`=3, `round`=9.
- `move`=11 in IDLE: one `bad_move` pulse, state IDLE, no `start` pulse, counters unchanged.
- `pred_ready` held 0, TIMEOUT=10:
  - JUDGE entered after 10 wait cycles; `timeout`=1 with `result_valid`.
  - `cpu_move` equals the fallback counter value sampled.
- ROUNDS=3, three rounds played:
  - `game_over`=1 after the third COMMIT; `move_ready`=0.
  - A fourth `move_valid` is ignored.
  - Reset clears everything; `move_ready`=1 on the next cycle.
- Reset asserted during WAIT_PRED: no `result_valid` or `start` pulse, scores stay 0. With the macro defined, `history`=0.
